layer_param_loader: RTL and testbench

- Sequences weight/bias loading for the 1D-CNN layer blocks, then enables the compute phase.
- On i_start it walks layers 0..N_LAYER-1. For each layer it pulses that layer's EN_w, reads the layer's parameter words from a synchronous parameter ROM, and streams them over the shared stb/ack bus.
- After the last layer goes idle it holds o_EN_c high for inference.
- Sits between the top-level host/control FSM and the layer_N instances.

---
 rtl/layer_param_loader_pkg.sv | 36 +++
 rtl/layer_param_loader_if.sv | 31 +++
 rtl/layer_param_loader_watchdog.sv | 39 +++
 rtl/layer_param_loader.sv | 159 +++++++++++++++
 tb/tb_layer_param_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_param_loader_pkg.sv
// -----------------------------------------------------------------------------
// layer_param_loader_pkg
// Shared definitions for the layer parameter loader:
//   - state_t          : loader FSM encoding (3 bits)
//   - TIMEOUT_DEFAULT  : default watchdog limit in cycles
//   - len_entry()      : extracts one entry from the packed per-layer length table
// -----------------------------------------------------------------------------
package layer_param_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_RUN   = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  // Widest length table the helper accepts; callers zero-extend into it.
  localparam int unsigned LEN_TBL_MAX_W = 1024;

  // Entry k of a packed table whose entries are lw bits wide (entry 0 in the
  // LSBs). Used with constant arguments only, so it folds away at elaboration.
  function automatic logic [31:0] len_entry(input logic [LEN_TBL_MAX_W-1:0] tbl,
                                            input int unsigned               k,
                                            input int unsigned               lw);
    logic [31:0] mask;
    mask      = (lw >= 32) ? '1 : ((32'd1 << lw) - 32'd1);
    len_entry = 32'(tbl >> (k * lw)) & mask;
  endfunction

endpackage

// File: rtl/layer_param_loader_if.sv
// -----------------------------------------------------------------------------
// layer_param_loader_if
// Parameter ROM read port plus the broadcast stb/ack parameter bus.
//   o_rom_en / o_rom_addr : ROM read request (loader -> ROM)
//   i_rom_data            : ROM read data, one cycle after o_rom_en
//   o_data / o_stb        : parameter word and its valid strobe (loader -> layers)
//   i_ack                 : OR of the layers' acknowledges
// The o_/i_ prefixes are from the loader's point of view.
// Modports: master = loader, slave = ROM and layer side.
// -----------------------------------------------------------------------------
interface layer_param_loader_if #(
  parameter int unsigned WW = 128,
  parameter int unsigned AW = 16
);
  logic          o_rom_en;
  logic [AW-1:0] o_rom_addr;
  logic [WW-1:0] i_rom_data;
  logic [WW-1:0] o_data;
  logic          o_stb;
  logic          i_ack;

  modport master (
    output o_rom_en, o_rom_addr, o_data, o_stb,
    input  i_rom_data, i_ack
  );

  modport slave (
    input  o_rom_en, o_rom_addr, o_data, o_stb,
    output i_rom_data, i_ack
  );
endinterface

// File: rtl/layer_param_loader_watchdog.sv
// -----------------------------------------------------------------------------
// layer_param_loader_watchdog
// Cycle counter guarding stalled transfers and layers that never go idle.
//   clk, RSTn : clock, asynchronous active-low reset
//   clr       : restart the count (has priority over en)
//   en        : count this cycle
//   expired   : en is high and this is the TIMEOUT-th counted cycle
// -----------------------------------------------------------------------------
module layer_param_loader_watchdog
  import layer_param_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // The count holds the number of earlier counted cycles, so the TIMEOUT-th
  // one sees TIMEOUT-1 and the owner reacts on that cycle's closing edge.
  assign expired = en && (cnt_q >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/layer_param_loader.sv
// -----------------------------------------------------------------------------
// layer_param_loader
// Walks layers 0..N_LAYER-1: pulses each layer's load enable, reads that
// layer's parameter words from a synchronous ROM and streams them over the
// shared stb/ack bus, then holds the compute enable high.
//   clk, RSTn      : clock, asynchronous active-low reset
//   i_start        : start (or restart) a load; honoured in IDLE, RUN and ERR
//   i_stop         : leave RUN for IDLE (i_start wins if both are high)
//   o_busy         : loading (every state except IDLE, RUN, ERR)
//   o_done         : one-cycle pulse on entry to RUN
//   o_err          : watchdog timeout, held until the next i_start
//   o_EN_w         : one-hot load-enable pulse to the layer being armed
//   o_EN_c         : compute enable, high in RUN
//   i_layer_busy   : per-layer busy flags
//   bus            : ROM read port and parameter stb/ack bus (master side)
// -----------------------------------------------------------------------------
module layer_param_loader
  import layer_param_loader_pkg::*;
#(
  parameter int unsigned             WW        = 128,
  parameter int unsigned             N_LAYER   = 4,
  parameter int unsigned             AW        = 16,
  parameter int unsigned             LW        = 16,
  parameter logic [N_LAYER*LW-1:0]   LAYER_LEN = {N_LAYER{16'd1}},
  parameter int unsigned             TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [N_LAYER-1:0] o_EN_w,
  output logic               o_EN_c,
  input  logic [N_LAYER-1:0] i_layer_busy,
  layer_param_loader_if.master bus
);

  localparam int unsigned KW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam logic [LEN_TBL_MAX_W-1:0] LEN_TBL = LEN_TBL_MAX_W'(LAYER_LEN);

  // Word count per layer, unpacked once from the packed table.
  logic [LW-1:0] len_tab [N_LAYER];
  for (genvar i = 0; i < N_LAYER; i++) begin : g_len
    assign len_tab[i] = LW'(len_entry(LEN_TBL, i, LW));
  end

  state_t        state_q, state_d;
  logic [KW-1:0] k_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] count_q;
  logic [WW-1:0] data_q;
  logic          done_q;
  logic          err_q;
  logic          drain_seen_q;

  logic xfer;
  logic last_word;
  logic last_layer;
  logic restart;
  logic next_layer;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  assign xfer       = (state_q == ST_SEND) && bus.i_ack;
  assign last_word  = (count_q == len_tab[k_q] - LW'(1));
  assign last_layer = (k_q == KW'(N_LAYER - 1));

  // NOTE: defaults first, so every path assigns state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_ARM;
      ST_ARM:   state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_SEND;
      ST_SEND: begin
        if (bus.i_ack)       state_d = last_word ? ST_DRAIN : ST_FETCH;
        else if (wd_expired) state_d = ST_ERR;
      end
      ST_DRAIN: begin
        // The layer's busy flag lags the last ack by a cycle, so the first
        // DRAIN cycle never decides.
        if (drain_seen_q && !i_layer_busy[k_q]) state_d = last_layer ? ST_RUN : ST_ARM;
        else if (wd_expired)                     state_d = ST_ERR;
      end
      ST_RUN: begin
        if (i_start)     state_d = ST_ARM;
        else if (i_stop) state_d = ST_IDLE;
      end
      ST_ERR:   if (i_start) state_d = ST_ARM;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign restart    = (state_d == ST_ARM) &&
                      (state_q inside {ST_IDLE, ST_RUN, ST_ERR});
  assign next_layer = (state_q == ST_DRAIN) && (state_d == ST_ARM);

  // Cleared on every transfer and every state change; counts only stalled
  // SEND cycles and DRAIN cycles.
  assign wd_clr = (state_d != state_q) || xfer;
  assign wd_en  = ((state_q == ST_SEND) && !bus.i_ack) || (state_q == ST_DRAIN);

  layer_param_loader_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_param_watchdog (
    .clk     (clk),
    .RSTn    (RSTn),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      drain_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= (state_d == ST_RUN) && (state_q != ST_RUN);
      err_q        <= (state_d == ST_ERR);
      drain_seen_q <= (state_q == ST_DRAIN) && (state_d == ST_DRAIN);

      // Layer bases fall out of the running address: it only rewinds on a
      // fresh load, never between layers.
      if (restart)   addr_q <= '0;
      else if (xfer) addr_q <= addr_q + AW'(1);

      if (restart)         k_q <= '0;
      else if (next_layer) k_q <= k_q + KW'(1);

      if (state_q == ST_ARM) count_q <= '0;
      else if (xfer)         count_q <= count_q + LW'(1);

      if (state_q == ST_WAIT) data_q <= bus.i_rom_data;
    end
  end

  assign o_busy         = !(state_q inside {ST_IDLE, ST_RUN, ST_ERR});
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_EN_c         = (state_q == ST_RUN);
  assign o_EN_w         = (state_q == ST_ARM) ? (N_LAYER'(1) << k_q) : '0;
  assign bus.o_rom_en   = (state_q == ST_FETCH);
  assign bus.o_rom_addr = addr_q;
  assign bus.o_data     = data_q;
  assign bus.o_stb      = (state_q == ST_SEND);

endmodule

// File: tb/tb_layer_param_loader.sv
// -----------------------------------------------------------------------------
// tb_layer_param_loader
// Two loaders on one clock/reset:
//   dut_a : N_LAYER=2, layer0=3 words, layer1=5 words, TIMEOUT=16, ack and
//           per-layer busy driven by the bench (busy drops 2 cycles after the
//           layer's last ack)
//   dut_b : N_LAYER=2, one word per layer, ack tied high, layers never busy
// Both ROMs return their own address as data.
// -----------------------------------------------------------------------------
module tb_layer_param_loader;

  localparam int unsigned WW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned NL = 2;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, ack_a = 1'b1;
  logic          busy_a, done_a, err_a, en_c_a;
  logic          busy_b, done_b, err_b, en_c_b;
  logic [NL-1:0] en_w_a, en_w_b, lbusy_a;

  layer_param_loader_if #(.WW(WW), .AW(AW)) bus_a ();
  layer_param_loader_if #(.WW(WW), .AW(AW)) bus_b ();

  layer_param_loader #(
    .WW(WW), .N_LAYER(NL), .AW(AW), .LW(LW),
    .LAYER_LEN({16'd5, 16'd3}), .TIMEOUT(TO)
  ) dut_a (
    .clk(clk), .RSTn(rstn), .i_start(start_a), .i_stop(stop_a),
    .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_EN_w(en_w_a),
    .o_EN_c(en_c_a), .i_layer_busy(lbusy_a), .bus(bus_a)
  );

  layer_param_loader #(
    .WW(WW), .N_LAYER(NL), .AW(AW), .LW(LW),
    .LAYER_LEN({16'd1, 16'd1}), .TIMEOUT(TO)
  ) dut_b (
    .clk(clk), .RSTn(rstn), .i_start(start_b), .i_stop(1'b0),
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_EN_w(en_w_b),
    .o_EN_c(en_c_b), .i_layer_busy(2'b00), .bus(bus_b)
  );

  assign bus_a.i_ack = ack_a;
  assign bus_b.i_ack = 1'b1;

  // Synchronous ROMs: data = address.
  always @(posedge clk) if (bus_a.o_rom_en) bus_a.i_rom_data <= WW'(bus_a.o_rom_addr);
  always @(posedge clk) if (bus_b.o_rom_en) bus_b.i_rom_data <= WW'(bus_b.o_rom_addr);

  // Layer model for dut_a: busy from its EN_w pulse until 2 cycles after its last ack.
  int cur = 0, left = 0, cd = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lbusy_a <= '0; cur <= 0; left <= 0; cd <= 0;
    end else if (en_w_a != '0) begin
      cur     <= en_w_a[1] ? 1 : 0;
      left    <= en_w_a[1] ? 5 : 3;
      lbusy_a <= lbusy_a | en_w_a;
      cd      <= 0;
    end else begin
      if (bus_a.o_stb && bus_a.i_ack) begin
        left <= left - 1;
        if (left == 1) cd <= 2;
      end
      if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) lbusy_a[cur] <= 1'b0;
      end
    end
  end

  // Monitor for dut_a, mid-cycle: transfers, EN_w pulses, done pulses, invariants.
  int xfer_data[$];
  int xfer_layer[$];
  int enw_log[$];
  int done_cnt = 0;
  int inv_bad  = 0;
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus_a.o_stb && bus_a.i_ack) begin
        xfer_data.push_back(int'(bus_a.o_data));
        xfer_layer.push_back(cur);
      end
      if (en_w_a != '0) enw_log.push_back(int'(en_w_a));
      if (done_a) done_cnt++;
      if ($countones(en_w_a) > 1 || (en_w_a != '0 && bus_a.o_stb)) inv_bad++;
    end
  end

  int pass_cnt = 0, total_cnt = 0;
  int mark_x = 0, mark_e = 0, mark_d = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mark();
    mark_x = xfer_data.size();
    mark_e = enw_log.size();
    mark_d = done_cnt;
  endtask

  task automatic pulse_start_a();
    tick(); start_a = 1'b1;
    tick(); start_a = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (en_c_a) ok = 1'b1;
    end
    total_cnt++;
    if (!ok) $display("FAIL %s_run_wait: o_EN_c still 0 after 300 cycles, want 1", tag);
    else pass_cnt++;
  endtask

  task automatic wait_stb(input string tag, input bit match, input logic [WW-1:0] val);
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus_a.o_stb && (!match || bus_a.o_data == val)) ok = 1'b1;
    end
    total_cnt++;
    if (!ok) $display("FAIL %s_stb_wait: o_stb (data %0d) not seen in 100 cycles", tag, val);
    else pass_cnt++;
  endtask

  // A complete load of dut_a: words 0..2 to layer0, 3..7 to layer1.
  task automatic verify_full_load(input string tag);
    int nx, ne;
    @(negedge clk);
    nx = xfer_data.size() - mark_x;
    ne = enw_log.size() - mark_e;
    total_cnt++;
    if (nx !== 8) $display("FAIL %s_xfer_count: got %0d want 8", tag, nx);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (i < nx) begin
        total_cnt++;
        if (xfer_data[mark_x+i] !== i || xfer_layer[mark_x+i] !== ((i < 3) ? 0 : 1))
          $display("FAIL %s_word%0d: got data %0d layer %0d want data %0d layer %0d",
                   tag, i, xfer_data[mark_x+i], xfer_layer[mark_x+i], i, (i < 3) ? 0 : 1);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (ne !== 2 || enw_log[mark_e] !== 1 || enw_log[mark_e+1] !== 2)
      $display("FAIL %s_en_w_seq: got %0d pulses, want 2 pulses 01 then 10", tag, ne);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - mark_d !== 1) $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt - mark_d);
    else pass_cnt++;
    total_cnt++;
    if ({en_c_a, busy_a, bus_a.o_stb} !== 3'b100)
      $display("FAIL %s_run_state: got en_c/busy/stb %b want 100", tag, {en_c_a, busy_a, bus_a.o_stb});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #2;
    ctl = {busy_a, done_a, err_a, en_c_a, en_w_a, bus_a.o_rom_en, bus_a.o_stb};
    total_cnt++;
    if (ctl !== 8'h00) $display("FAIL reset_ctrl_a: got %b want 00000000", ctl);
    else pass_cnt++;
    total_cnt++;
    if ({bus_a.o_data, bus_a.o_rom_addr} !== '0)
      $display("FAIL reset_bus_a: got data %0h addr %0h want 0 0", bus_a.o_data, bus_a.o_rom_addr);
    else pass_cnt++;
    ctl = {busy_b, done_b, err_b, en_c_b, en_w_b, bus_b.o_rom_en, bus_b.o_stb};
    total_cnt++;
    if (ctl !== 8'h00) $display("FAIL reset_ctrl_b: got %b want 00000000", ctl);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy_a, en_w_a, en_c_a} !== 4'b0000)
      $display("FAIL reset_idle_hold: got busy/en_w/en_c %b want 0000", {busy_a, en_w_a, en_c_a});
    else pass_cnt++;
  endtask

  task automatic test_single_word();
    logic [6:0] exp_b [14];
    logic [6:0] got;
    exp_b = '{7'b0100100, 7'b0010100, 7'b0000100, 7'b0001100, 7'b0000100,
              7'b0000100, 7'b1000100, 7'b0010100, 7'b0000100, 7'b0001100,
              7'b0000100, 7'b0000100, 7'b0000011, 7'b0000010};
    tick(); start_b = 1'b1;
    tick(); start_b = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      got = {en_w_b, bus_b.o_rom_en, bus_b.o_stb, busy_b, en_c_b, done_b};
      total_cnt++;
      if (got !== exp_b[i])
        $display("FAIL single_cycle%0d: got en_w/rom_en/stb/busy/en_c/done %b want %b", i + 1, got, exp_b[i]);
      else pass_cnt++;
      if (i == 1 || i == 7) begin
        total_cnt++;
        if (bus_b.o_rom_addr !== AW'((i == 1) ? 0 : 1))
          $display("FAIL single_addr%0d: got %0d want %0d", i + 1, bus_b.o_rom_addr, (i == 1) ? 0 : 1);
        else pass_cnt++;
      end
      if (i == 3 || i == 9) begin
        total_cnt++;
        if (bus_b.o_data !== WW'((i == 3) ? 0 : 1))
          $display("FAIL single_data%0d: got %0d want %0d", i + 1, bus_b.o_data, (i == 3) ? 0 : 1);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_basic_load();
    ack_a = 1'b1;
    mark();
    pulse_start_a();
    wait_run("basic");
    verify_full_load("basic");
  endtask

  task automatic test_ack_stall();
    logic [WW+AW:0] got;
    mark();
    pulse_start_a();
    wait_stb("stall_w0", 1'b0, '0);
    tick(); ack_a = 1'b0;
    wait_stb("stall_w1", 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      got = {bus_a.o_stb, bus_a.o_data, bus_a.o_rom_addr};
      total_cnt++;
      if (got !== {1'b1, WW'(1), AW'(1)})
        $display("FAIL stall_hold%0d: got stb %b data %0d addr %0d want 1 1 1",
                 i, bus_a.o_stb, bus_a.o_data, bus_a.o_rom_addr);
      else pass_cnt++;
    end
    tick(); ack_a = 1'b1;
    wait_run("stall");
    verify_full_load("stall");
  endtask

  task automatic test_timeout();
    bit bad = 1'b0;
    tick(); ack_a = 1'b0;
    pulse_start_a();
    wait_stb("timeout", 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (err_a !== 1'b0 || bus_a.o_stb !== 1'b1) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL timeout_early: o_err rose or o_stb fell within 16 SEND cycles");
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({err_a, bus_a.o_stb, busy_a, en_c_a} !== 4'b1000)
      $display("FAIL timeout_err: got err/stb/busy/en_c %b want 1000", {err_a, bus_a.o_stb, busy_a, en_c_a});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (err_a !== 1'b1) $display("FAIL timeout_sticky: got o_err %b want 1", err_a);
    else pass_cnt++;
    tick(); ack_a = 1'b1;
    mark();
    pulse_start_a();
    @(negedge clk);
    total_cnt++;
    if ({err_a, en_w_a} !== 3'b001)
      $display("FAIL timeout_restart_arm: got err/en_w %b want 001", {err_a, en_w_a});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus_a.o_rom_en, bus_a.o_rom_addr} !== {1'b1, AW'(0)})
      $display("FAIL timeout_restart_fetch: got rom_en %b addr %0d want 1 0", bus_a.o_rom_en, bus_a.o_rom_addr);
    else pass_cnt++;
    wait_run("timeout_reload");
    verify_full_load("timeout_reload");
  endtask

  task automatic test_reset_mid();
    logic [7:0] ctl;
    mark();
    pulse_start_a();
    wait_stb("rst_mid", 1'b1, WW'(5));
    #1 rstn = 1'b0;
    #1;
    ctl = {busy_a, done_a, err_a, en_c_a, en_w_a, bus_a.o_rom_en, bus_a.o_stb};
    total_cnt++;
    if (ctl !== 8'h00) $display("FAIL rst_mid_ctrl: got %b want 00000000", ctl);
    else pass_cnt++;
    total_cnt++;
    if ({bus_a.o_data, bus_a.o_rom_addr} !== '0)
      $display("FAIL rst_mid_bus: got data %0d addr %0d want 0 0", bus_a.o_data, bus_a.o_rom_addr);
    else pass_cnt++;
    tick(); tick(); rstn = 1'b1;
    mark();
    pulse_start_a();
    @(negedge clk);
    total_cnt++;
    if (en_w_a !== 2'b01) $display("FAIL rst_mid_arm: got en_w %b want 01", en_w_a);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus_a.o_rom_en, bus_a.o_rom_addr} !== {1'b1, AW'(0)})
      $display("FAIL rst_mid_fetch: got rom_en %b addr %0d want 1 0", bus_a.o_rom_en, bus_a.o_rom_addr);
    else pass_cnt++;
    wait_run("rst_mid");
    verify_full_load("rst_mid");
  endtask

  task automatic test_start_stop();
    mark();
    tick(); start_a = 1'b1; stop_a = 1'b1;
    tick(); start_a = 1'b0; stop_a = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({en_c_a, en_w_a} !== 3'b001)
      $display("FAIL start_stop_prio: got en_c/en_w %b want 001", {en_c_a, en_w_a});
    else pass_cnt++;
    wait_run("start_stop");
    verify_full_load("start_stop");
    tick(); stop_a = 1'b1;
    tick(); stop_a = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({en_c_a, busy_a, en_w_a} !== 4'b0000)
      $display("FAIL stop_idle: got en_c/busy/en_w %b want 0000", {en_c_a, busy_a, en_w_a});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({en_c_a, busy_a, en_w_a, bus_a.o_rom_en} !== 5'b00000)
      $display("FAIL stop_stays_idle: got en_c/busy/en_w/rom_en %b want 00000",
               {en_c_a, busy_a, en_w_a, bus_a.o_rom_en});
    else pass_cnt++;
  endtask

  task automatic test_invariants();
    total_cnt++;
    if (inv_bad !== 0) $display("FAIL en_w_invariant: %0d cycles with multi-hot EN_w or EN_w with stb, want 0", inv_bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_basic_load();
    test_ack_stall();
    test_timeout();
    test_reset_mid();
    test_start_stop();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
